// File: rtl/pipeline_pkg.sv
// Shared stage indices and controller mode encoding for the in-order core pipeline.
package pipeline_pkg;

    localparam int unsigned STG_IFID  = 0;
    localparam int unsigned STG_IDEX  = 1;
    localparam int unsigned STG_EXMEM = 2;
    localparam int unsigned STG_MEMWB = 3;

    typedef enum logic [1:0] {
        MODE_RUN = 2'd0,
        MODE_HAZ = 2'd1,
        MODE_MC  = 2'd2,
        MODE_EXC = 2'd3
    } mode_e;

endpackage

// File: rtl/pipeline_stage_ctrl_hazard_timer.sv
// Hazard freeze down-counter: load, decrement, clear or hold; busy while non-zero.
module hazard_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         busy_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Pipeline enable/flush/valid controller: one control slice per pipeline register,
// with multi-cycle freeze, hazard bubbles, exception prefix flush and a stall counter.
module pipeline_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned NREG      = 4,
    parameter int unsigned HAZ_STAGE = 0,
    parameter int unsigned EXC_STAGE = 2,
    parameter int unsigned HLEN_W    = 2,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_mc_busy,
    input  logic              i_hazard,
    input  logic [HLEN_W-1:0] i_hazard_len,
    input  logic              i_exc,
    output logic [NREG-1:0]   o_ena,
    output logic [NREG-1:0]   o_flush,
    output logic [NREG-1:0]   o_valid,
    output logic              o_hazard_busy,
    output logic [PERF_W-1:0] o_stall_cnt
);

    if (HAZ_STAGE >= NREG - 1) begin : g_bad_haz
        $error("pipeline_stage_ctrl: HAZ_STAGE must be below NREG-1");
    end
    if (EXC_STAGE >= NREG) begin : g_bad_exc
        $error("pipeline_stage_ctrl: EXC_STAGE must be below NREG");
    end
    if (HLEN_W < 1) begin : g_bad_hlen
        $error("pipeline_stage_ctrl: HLEN_W must be at least 1");
    end

    mode_e              mode_c;
    logic               busy_q;
    logic               tmr_busy;
    logic [HLEN_W-1:0]  tmr_load_val;
    logic [NREG-1:0]    ena_c;
    logic [NREG-1:0]    flush_c;
    logic [NREG-1:0]    valid_q;
    logic [NREG-1:0]    valid_d;
    logic [NREG-1:0]    valid_shift;
    logic [PERF_W-1:0]  stall_q;
    logic [PERF_W-1:0]  stall_d;

    // Priority: exception beats multi-cycle freeze beats hazard beats run.
    always_comb begin
        mode_c = MODE_RUN;
        if (i_exc) begin
            mode_c = MODE_EXC;
        end else if (busy_q) begin
            mode_c = MODE_MC;
        end else if (tmr_busy || i_hazard) begin
            mode_c = MODE_HAZ;
        end
    end

    assign valid_shift = {valid_q[NREG-2:0], 1'b1};

    always_comb begin
        ena_c   = '1;
        flush_c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            unique case (mode_c)
                MODE_EXC: begin
                    if (i <= EXC_STAGE) begin
                        ena_c[i]   = 1'b0;
                        flush_c[i] = 1'b1;
                    end
                end
                MODE_MC: ena_c[i] = 1'b0;
                MODE_HAZ: begin
                    if (i <= HAZ_STAGE) begin
                        ena_c[i] = 1'b0;
                    end else if (i == HAZ_STAGE + 1) begin
                        flush_c[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // A loading register takes its predecessor's valid; a cleared one goes empty.
        valid_d = (ena_c & valid_shift) | (~ena_c & valid_q);
        valid_d = valid_d & ~flush_c;
    end

    assign tmr_load_val = (i_hazard_len == '0) ? '0 : i_hazard_len - HLEN_W'(1);

    hazard_timer #(
        .W          (HLEN_W)
    ) u_hazard_timer (
        .clk        (clk),
        .resetn     (resetn),
        .clear_i    (mode_c == MODE_EXC),
        .load_i     ((mode_c == MODE_HAZ) && !tmr_busy),
        .dec_i      ((mode_c == MODE_HAZ) && tmr_busy),
        .load_val_i (tmr_load_val),
        .busy_o     (tmr_busy)
    );

    always_comb begin
        stall_d = stall_q;
        if (!ena_c[STG_IFID] && (stall_q != '1)) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b0;
            valid_q <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= i_mc_busy;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign o_ena         = ena_c;
    assign o_flush       = flush_c;
    assign o_valid       = valid_q;
    assign o_hazard_busy = tmr_busy;
    assign o_stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed bench for pipeline_stage_ctrl with default parameters (NREG=4).
module tb_pipeline_stage_ctrl;

    logic        clk;
    logic        resetn;
    logic        i_mc_busy;
    logic        i_hazard;
    logic [1:0]  i_hazard_len;
    logic        i_exc;
    logic [3:0]  o_ena;
    logic [3:0]  o_flush;
    logic [3:0]  o_valid;
    logic        o_hazard_busy;
    logic [31:0] o_stall_cnt;

    int n_total;
    int n_pass;

    pipeline_stage_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_mc_busy     (i_mc_busy),
        .i_hazard      (i_hazard),
        .i_hazard_len  (i_hazard_len),
        .i_exc         (i_exc),
        .o_ena         (o_ena),
        .o_flush       (o_flush),
        .o_valid       (o_valid),
        .o_hazard_busy (o_hazard_busy),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fill_exp [5];

    initial begin
        n_total      = 0;
        n_pass       = 0;
        resetn       = 1'b0;
        i_mc_busy    = 1'b0;
        i_hazard     = 1'b0;
        i_hazard_len = 2'd0;
        i_exc        = 1'b0;
        fill_exp[0]  = 4'b0001;
        fill_exp[1]  = 4'b0011;
        fill_exp[2]  = 4'b0111;
        fill_exp[3]  = 4'b1111;
        fill_exp[4]  = 4'b1111;

        repeat (2) tick();
        check("rst_valid", 64'(o_valid), 64'h0);
        check("rst_stall", 64'(o_stall_cnt), 64'h0);
        check("rst_hbusy", 64'(o_hazard_busy), 64'h0);
        resetn = 1'b1;
        #1;
        check("rst_ena", 64'(o_ena), 64'hF);
        check("rst_flush", 64'(o_flush), 64'h0);

        // fill ramp
        for (int k = 0; k < 5; k++) begin
            tick();
            check("fill_valid", 64'(o_valid), 64'(fill_exp[k]));
            check("fill_ena", 64'(o_ena), 64'hF);
        end

        // hazard len=2: two frozen cycles, bubble into register 1
        i_hazard = 1'b1; i_hazard_len = 2'd2;
        #1;
        check("haz_ena0", 64'(o_ena), 64'hE);
        check("haz_flush0", 64'(o_flush), 64'h2);
        check("haz_hbusy0", 64'(o_hazard_busy), 64'h0);
        tick();
        i_hazard = 1'b0;
        #1;
        check("haz_ena1", 64'(o_ena), 64'hE);
        check("haz_flush1", 64'(o_flush), 64'h2);
        check("haz_hbusy1", 64'(o_hazard_busy), 64'h1);
        check("haz_valid1", 64'(o_valid), 64'hD);
        tick();
        check("haz_ena2", 64'(o_ena), 64'hF);
        check("haz_hbusy2", 64'(o_hazard_busy), 64'h0);
        check("haz_valid2", 64'(o_valid), 64'h9);
        check("haz_stall", 64'(o_stall_cnt), 64'd2);
        repeat (4) tick();
        check("haz_refill", 64'(o_valid), 64'hF);

        // hazard len=0 behaves as a single-cycle freeze
        i_hazard = 1'b1; i_hazard_len = 2'd0;
        #1;
        check("len0_ena0", 64'(o_ena), 64'hE);
        tick();
        i_hazard = 1'b0;
        #1;
        check("len0_ena1", 64'(o_ena), 64'hF);
        check("len0_hbusy", 64'(o_hazard_busy), 64'h0);
        check("len0_stall", 64'(o_stall_cnt), 64'd3);
        repeat (4) tick();

        // multi-cycle busy for 3 cycles: freeze lags by one cycle
        i_mc_busy = 1'b1;
        #1;
        check("mc_ena_c1", 64'(o_ena), 64'hF);
        tick();
        check("mc_ena_c2", 64'(o_ena), 64'h0);
        check("mc_flush_c2", 64'(o_flush), 64'h0);
        tick();
        check("mc_ena_c3", 64'(o_ena), 64'h0);
        tick();
        i_mc_busy = 1'b0;
        #1;
        check("mc_ena_c4", 64'(o_ena), 64'h0);
        check("mc_valid", 64'(o_valid), 64'hF);
        tick();
        check("mc_ena_c5", 64'(o_ena), 64'hF);
        check("mc_stall", 64'(o_stall_cnt), 64'd6);

        // hazard raised during MC waits until MC ends
        i_mc_busy = 1'b1;
        tick();
        i_mc_busy = 1'b0; i_hazard = 1'b1; i_hazard_len = 2'd1;
        #1;
        check("mchaz_ena0", 64'(o_ena), 64'h0);
        check("mchaz_flush0", 64'(o_flush), 64'h0);
        tick();
        check("mchaz_hbusy", 64'(o_hazard_busy), 64'h0);
        check("mchaz_ena1", 64'(o_ena), 64'hE);
        check("mchaz_flush1", 64'(o_flush), 64'h2);
        tick();
        i_hazard = 1'b0;
        #1;
        check("mchaz_ena2", 64'(o_ena), 64'hF);
        check("mchaz_valid", 64'(o_valid), 64'hD);
        check("mchaz_stall", 64'(o_stall_cnt), 64'd8);
        repeat (4) tick();

        // exception while freeze counter = 1 cancels the freeze
        i_hazard = 1'b1; i_hazard_len = 2'd2;
        tick();
        i_hazard = 1'b0; i_exc = 1'b1;
        #1;
        check("excfrz_ena", 64'(o_ena), 64'h8);
        check("excfrz_flush", 64'(o_flush), 64'h7);
        tick();
        i_exc = 1'b0;
        #1;
        check("excfrz_valid", 64'(o_valid), 64'h8);
        check("excfrz_hbusy", 64'(o_hazard_busy), 64'h0);
        check("excfrz_ena1", 64'(o_ena), 64'hF);
        check("excfrz_stall", 64'(o_stall_cnt), 64'd10);

        // exception in the same cycle as busy_q=1: flush wins
        i_mc_busy = 1'b1;
        tick();
        i_mc_busy = 1'b0; i_exc = 1'b1;
        #1;
        check("excmc_ena", 64'(o_ena), 64'h8);
        check("excmc_flush", 64'(o_flush), 64'h7);
        tick();
        i_exc = 1'b0;
        #1;
        check("excmc_valid", 64'(o_valid), 64'h0);
        check("excmc_stall", 64'(o_stall_cnt), 64'd11);
        repeat (4) tick();

        // async reset mid-freeze (cnt=2)
        i_hazard = 1'b1; i_hazard_len = 2'd3;
        tick();
        i_hazard = 1'b0;
        #1;
        check("rstfrz_hbusy_pre", 64'(o_hazard_busy), 64'h1);
        resetn = 1'b0;
        #1;
        check("rstfrz_valid", 64'(o_valid), 64'h0);
        check("rstfrz_hbusy", 64'(o_hazard_busy), 64'h0);
        check("rstfrz_stall", 64'(o_stall_cnt), 64'h0);
        resetn = 1'b1;
        #1;
        check("rstfrz_ena", 64'(o_ena), 64'hF);
        check("rstfrz_flush", 64'(o_flush), 64'h0);
        tick();
        check("rstfrz_valid1", 64'(o_valid), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
